// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: operation codes,
// FSM states and small operation-class helpers.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MDOp_mul    = 3'd0,
    MDOp_mulh   = 3'd1,
    MDOp_mulhsu = 3'd2,
    MDOp_mulhu  = 3'd3,
    MDOp_div    = 3'd4,
    MDOp_divu   = 3'd5,
    MDOp_rem    = 3'd6,
    MDOp_remu   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input md_op_e op);
    return op inside {MDOp_mulh, MDOp_mulhsu, MDOp_div, MDOp_rem};
  endfunction

  function automatic logic op_b_signed(input md_op_e op);
    return op inside {MDOp_mulh, MDOp_div, MDOp_rem};
  endfunction

endpackage

// File: rtl/muldiv_unit_md_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module md_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_div,
  input  logic            i_bit,
  output logic [XLEN-1:0] o_rem,
  output logic            o_q
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  // Partial remainder stays below the divisor, so bit XLEN of the difference is a valid borrow.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_div};
  assign o_q     = ~w_diff[XLEN];
  assign o_rem   = o_q ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      MDOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] C
);
  import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  md_state_e           r_state, w_state_next;
  md_op_e              r_op, w_op;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_a, r_hi, r_lo, r_c, r_spec_res;
  logic                r_neg_q, r_neg_r, r_special;
  logic [XLEN-1:0]     w_abs_a, w_abs_b, w_spec_res, w_res, w_drem;
  logic                w_sa, w_sb, w_b_zero, w_ovf, w_special, w_accept, w_qbit;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_prod, w_prod_fix;

  assign w_op     = md_op_e'(MDOp);
  assign w_sa     = op_a_signed(w_op) & A[XLEN-1];
  assign w_sb     = op_b_signed(w_op) & B[XLEN-1];
  assign w_abs_a  = w_sa ? -A : A;
  assign w_abs_b  = w_sb ? -B : B;
  assign w_b_zero = (B == '0);
  assign w_ovf    = (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1) &&
                    (w_op == MDOp_div || w_op == MDOp_rem);
  assign w_special = op_is_div(w_op) && (w_b_zero || w_ovf);
  assign w_accept  = (r_state == MD_IDLE) && start && !flush;

  always_comb begin
    w_spec_res = '0;
    unique case (w_op)
      MDOp_div, MDOp_divu: w_spec_res = w_b_zero ? '1 : A;
      MDOp_rem, MDOp_remu: w_spec_res = w_b_zero ? A : '0;
      default:             w_spec_res = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      MD_IDLE: if (start)
                 w_state_next = (w_special || (FAST_MUL && !op_is_div(w_op))) ? MD_FIX : MD_CALC;
      MD_CALC: if (r_cnt == CNT_W'(1)) w_state_next = MD_FIX;
      MD_FIX:  w_state_next = MD_DONE;
      MD_DONE: w_state_next = MD_IDLE;
    endcase
    if (flush) w_state_next = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_state_next;
  end

  md_div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem (r_hi),
    .i_div (r_a),
    .i_bit (r_lo[XLEN-1]),
    .o_rem (w_drem),
    .o_q   (w_qbit)
  );

  // Shift-add: {r_hi, r_lo} holds partial product and remaining multiplier bits.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);

`ifdef MULDIV_FAST_MUL_EN
  assign w_prod = op_is_div(r_op) ? {r_hi, r_lo}
                                  : {{XLEN{1'b0}}, r_a} * {{XLEN{1'b0}}, r_lo};
`else
  assign w_prod = {r_hi, r_lo};
`endif

  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  always_comb begin
    w_res = '0;
    unique case (r_op)
      MDOp_mul:                          w_res = w_prod_fix[XLEN-1:0];
      MDOp_mulh, MDOp_mulhsu, MDOp_mulhu: w_res = w_prod_fix[2*XLEN-1:XLEN];
      MDOp_div, MDOp_divu:               w_res = r_neg_q ? -r_lo : r_lo;
      MDOp_rem, MDOp_remu:               w_res = r_neg_r ? -r_hi : r_hi;
    endcase
    if (r_special) w_res = r_spec_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= MDOp_mul;
      r_cnt      <= '0;
      r_a        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_c        <= '0;
      r_spec_res <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
    end else if (w_accept) begin
      r_op       <= w_op;
      r_cnt      <= CNT_W'(XLEN);
      r_hi       <= '0;
      r_spec_res <= w_spec_res;
      r_special  <= w_special;
      r_neg_q    <= w_sa ^ w_sb;
      r_neg_r    <= w_sa;
      r_a        <= op_is_div(w_op) ? w_abs_b : w_abs_a;
      r_lo       <= op_is_div(w_op) ? w_abs_a : w_abs_b;
    end else if (!flush) begin
      if (r_state == MD_CALC) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (op_is_div(r_op)) begin
          r_hi <= w_drem;
          r_lo <= {r_lo[XLEN-2:0], w_qbit};
        end else begin
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
        end
      end
      if (r_state == MD_FIX) r_c <= w_res;
    end
  end

  assign busy = (r_state != MD_IDLE);
  assign done = (r_state == MD_DONE);
  assign C    = r_c;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, special cases,
// flush/reset interruption and randomised operations against a reference model.
module tb_muldiv_unit;
  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] C;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_c;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .MDOp(MDOp),
    .A(A), .B(B), .busy(busy), .done(done), .C(C)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sub, p;
    logic [63:0]        ua, ub, up;
    logic signed [31:0] qa, qb;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sub = ub;
    qa  = a;
    qb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * sub; return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(qa / qb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(qa % qb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = op[2] && ((b == 0) ||
              (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && (op == 3'd4 || op == 3'd6)));
    if (special) return 2;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 2;
`endif
    return XLEN + 2;
  endfunction

  // Issues one operation; poke_at > 0 raises a stray start in that CALC cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int poke_at);
    int  lat, bcnt, exp_lat;
    bit  got;
    logic [31:0] want;
    lat = 0; bcnt = 0; got = 0;
    exp_lat = exp_latency(op, a, b);
    @(negedge clk);
    start = 1'b1; MDOp = op; A = a; B = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 200 && !got; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin got = 1; lat = n; end
      if (n == poke_at) begin
        start = 1'b1; MDOp = 3'd0; A = $urandom; B = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    want = exp_q.pop_front();
    chk_eq({tag, "_done_seen"}, 32'(got), 32'd1);
    chk_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk_eq({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat));
    chk_eq({tag, "_C"}, C, want);
    last_c = want;
    @(negedge clk);
    chk_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk_eq({tag, "_C_hold"}, C, want);
  endtask

  initial begin
    bit saw;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; MDOp = 3'd0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_C", C, 32'd0);
    rst = 1'b0;
    last_c = '0;

    run_op("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulh",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 5);
    run_op("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
    run_op("divu",    3'd5, 32'h8000_0000,  32'd3,         32'h2AAA_AAAA, 0);
    run_op("div_z",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
    run_op("remu_z",  3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234, 0);
    run_op("divu_z",  3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF, 0);
    run_op("rem_z",   3'd6, 32'hFFFF_FF00,  32'd0,         32'hFFFF_FF00, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("mul_min", 3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);

    // Flush in the middle of a divide: no done, C keeps the previous result.
    @(negedge clk);
    start = 1'b1; MDOp = 3'd4; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    chk_eq("flush_busy", 32'(busy), 32'd0);
    chk_eq("flush_done", 32'(done), 32'd0);
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw = 1;
    end
    chk_eq("flush_no_done", 32'(saw), 32'd0);
    chk_eq("flush_C_hold", C, last_c);

    // start together with flush in IDLE must be ignored.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; MDOp = 3'd0; A = 32'd3; B = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk_eq("startflush_busy", 32'(busy), 32'd0);
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw = 1;
    end
    chk_eq("startflush_no_done", 32'(saw), 32'd0);
    chk_eq("startflush_C_hold", C, last_c);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; MDOp = 3'd5; A = 32'd1000; B = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk_eq("midrst_busy", 32'(busy), 32'd0);
    chk_eq("midrst_done", 32'(done), 32'd0);
    chk_eq("midrst_C", C, 32'd0);
    last_c = '0;
    run_op("post_rst", 3'd5, 32'd1000, 32'd9, 32'd111, 0);

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb, ref_res(rop, ra, rb), 0);
    end

    chk_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
